conv_tile_scheduler: RTL
========================

Name: conv_tile_scheduler

Overview:
- Sequences the 32-lane Convolution engine over one frame of IFM tiles.
- Gates source tiles into the engine's in_valid under a credit limit, tracks in-flight tiles, and captures every out_valid/Out_OFM beat into a result FIFO.
- Drains results to a downstream consumer over valid/ready, then reports frame completion or a watchdog error.
- Sits between the IFM tile buffer and the Convolution instance. IFM data wires bypass this block; only control passes through it.

Parameters:
- OFM_W, 13, engine result width (matches Out_OFM).
- MAX_INFLIGHT, 4, maximum tiles in flight plus results buffered; also the FIFO depth (power of 2, ≥2).
- CNT_W, 8, width of the tile count and index.
- TIMEOUT, 255, watchdog limit in cycles.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame start pulse.
- cfg_tiles  in  CNT_W  tiles in the frame; latched on an accepted start.
- tile_valid  in  1  source has a tile on the IFM wires.
- tile_ready  out  1  scheduler accepts the tile this cycle.
- eng_in_valid  out  1  drives Convolution in_valid.
- eng_out_valid  in  1  Convolution out_valid.
- eng_ofm  in  OFM_W  Convolution Out_OFM.
- res_valid  out  1  result FIFO head is valid.
- res_ready  in  1  consumer accepts the head.
- res_data  out  OFM_W  result value.
- res_index  out  CNT_W  tile index of the result (0-based).
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle frame-complete pulse.
- err_timeout  out  1  sticky watchdog error.
- err_spurious  out  1  one-cycle pulse when an unexpected eng_out_valid arrives.

Behaviour:
- Reset: state=IDLE. All counters 0 and FIFO empty. Every output is 0 in the cycle after rst is sampled high. rst overrides all other inputs, including mid-frame; in-flight engine results arriving after reset count as spurious.
- States:
  - IDLE→RUN on start with cfg_tiles≠0: latch total=cfg_tiles; clear issued, returned and watchdog.
  - IDLE→DONE on start with cfg_tiles=0. done is then high in the next cycle and no eng_in_valid is issued.
  - RUN→DRAIN on the cycle issued reaches total.
  - DRAIN→DONE when returned==total and the FIFO is empty.
  - DONE→IDLE unconditionally. done=1 only while in DONE.
  - Any state with watchdog==TIMEOUT→ERR. In ERR: err_timeout=1 and tile_ready=0. ERR→RUN on start with a nonzero cfg_tiles; this clears err_timeout and relatches the config. A start with cfg_tiles=0 in ERR→DONE and clears err_timeout.
  - start is ignored in RUN, DRAIN and DONE.
- Credit: inflight = issued − returned.
  - tile_ready = (state==RUN) && (inflight + fifo_count < MAX_INFLIGHT). This is combinational from registered state.
  - eng_in_valid = tile_valid && tile_ready, combinational, zero latency. Each such cycle issued +1.
  - The credit rule guarantees the FIFO never overflows even though the engine cannot be stalled.
- Return path: eng_out_valid with inflight>0 (evaluated before this cycle's issue) pushes {returned, eng_ofm}, then returned +1. Otherwise the beat is dropped and err_spurious pulses the next cycle. The engine returns in order, and the return latency is arbitrary ≥1.
- Simultaneous issue and return: inflight is unchanged.
- Simultaneous push and pop: fifo_count is unchanged. A push to an empty FIFO appears on res_valid the next cycle.
- Result FIFO:
  - Show-ahead; res_valid = fifo_count≠0.
  - Pop on res_valid && res_ready.
  - res_data and res_index hold their values while res_ready is low.
  - Pointers wrap modulo MAX_INFLIGHT.
- Watchdog: in RUN or DRAIN, increments each cycle with inflight>0 and no eng_out_valid. It clears on any valid return and holds at 0 when inflight==0. A stalled consumer alone never trips it.
- Counters are CNT_W bits. total ≤ 2^CNT_W−1, so the counters never wrap within a frame.

Test Plan:
- cfg_tiles=3, tile_valid=1 always, engine latency 2, res_ready=1 → eng_in_valid high 3 cycles; results with res_index 0,1,2 in order; done pulses once after the last pop; busy low the following cycle.
- MAX_INFLIGHT=4, cfg_tiles=8, res_ready=0 → exactly 4 tiles accepted, then tile_ready stays 0. Raising res_ready → remaining 4 accepted; 8 results with indices 0–7, none lost or duplicated.
- cfg_tiles=2, engine never responds → err_timeout rises after 255 stalled cycles; state ERR; tile_ready=0. start with cfg_tiles=1 → err_timeout=0 and normal completion.
- start with cfg_tiles=0 → done=1 on the next cycle; eng_in_valid never asserted; busy stays 0.
- eng_out_valid pulse in IDLE with eng_ofm=13'h1ABC → err_spurious one cycle later; res_valid stays 0.
- rst asserted mid-RUN with 2 tiles in flight and 1 buffered → the next cycle has all outputs 0 and the FIFO empty. The 2 late engine beats → two err_spurious pulses and no res_valid.

Source files
------------

// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler: credit-gated tile issue to the convolution engine,
// in-order result capture into a show-ahead FIFO, and frame completion/watchdog.
module conv_tile_scheduler #(
    parameter int OFM_W        = 13,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_tiles,
    input  logic             tile_valid,
    output logic             tile_ready,
    output logic             eng_in_valid,
    input  logic             eng_out_valid,
    input  logic [OFM_W-1:0] eng_ofm,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OFM_W-1:0] res_data,
    output logic [CNT_W-1:0] res_index,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_spurious
);
    localparam int AW = $clog2(MAX_INFLIGHT);
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ERR} state_t;
    state_t           state, state_d;
    logic [CNT_W-1:0] total, issued, returned, inflight;
    logic [WW-1:0]    wd;
    logic [AW:0]      fifo_count;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [OFM_W-1:0] mem_data [MAX_INFLIGHT];
    logic [CNT_W-1:0] mem_idx [MAX_INFLIGHT];
    logic [CNT_W:0]   credit_used;
    logic             spur_q, push, pop, relatch, active;

    assign inflight     = issued - returned;
    // Buffered results hold credit too, so the unstallable engine can never overflow the FIFO
    assign credit_used  = {1'b0, inflight} + (CNT_W+1)'(fifo_count);
    assign active       = state == RUN || state == DRAIN;
    assign tile_ready   = state == RUN && credit_used < (CNT_W+1)'(MAX_INFLIGHT);
    assign eng_in_valid = tile_valid && tile_ready;
    assign push         = eng_out_valid && inflight != '0;
    assign res_valid    = fifo_count != '0;
    assign pop          = res_valid && res_ready;
    assign res_data     = res_valid ? mem_data[rd_ptr] : '0;
    assign res_index    = res_valid ? mem_idx[rd_ptr] : '0;
    assign busy         = active;
    assign done         = state == DONE;
    assign err_timeout  = state == ERR;
    assign err_spurious = spur_q;

    always_comb begin
        state_d = state;
        relatch = 1'b0;
        if (active && wd == WW'(TIMEOUT)) state_d = ERR;
        else if ((state == IDLE || state == ERR) && start) begin
            state_d = cfg_tiles == '0 ? DONE : RUN;
            relatch = cfg_tiles != '0;
        end
        else if (state == RUN && issued + CNT_W'(eng_in_valid) == total) state_d = DRAIN;
        else if (state == DRAIN && returned == total && fifo_count == '0) state_d = DONE;
        else if (state == DONE) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            total      <= '0;
            issued     <= '0;
            returned   <= '0;
            wd         <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            spur_q     <= 1'b0;
        end else begin
            state      <= state_d;
            spur_q     <= eng_out_valid && inflight == '0;
            total      <= relatch ? cfg_tiles : total;
            issued     <= relatch ? '0 : issued + CNT_W'(eng_in_valid);
            returned   <= relatch ? '0 : returned + CNT_W'(push);
            wd         <= (!active || push || inflight == '0) ? '0 : wd + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= eng_ofm;
            mem_idx[wr_ptr]  <= returned;
        end
    end
endmodule
